idx_sync_barrier: RTL

- Sits between the per-cluster vector macros and the global load/store unit.
- Consumes each cluster's idx_completed pulse and produces the idx_completed_sync pulse that all clusters wait on before retiring an indexed memory operation.
- Implements a registered, reusable barrier over the currently active clusters.
- Also maintains barrier statistics and an error flag.

---
 rtl/idx_sync_barrier.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/idx_sync_barrier.sv
// idx_sync_barrier: reusable barrier between the per-cluster vector macros
// and the global load/store unit. Each active cluster reports idx_completed;
// once every active cluster has reported, all active clusters receive a
// single-cycle idx_completed_sync pulse. The block also keeps a count of
// released barriers and a sticky duplicate-arrival error flag.
//
// Optional build macro: IDX_SYNC_TIMEOUT_EN
//    When defined, a watchdog counts cycles spent collecting arrivals and
//    raises the sticky timeout_o flag after TimeoutCycles cycles. When it is
//    not defined, timeout_o is tied to 0 and no counter exists.
module idx_sync_barrier #(
   parameter int NrClusters    = 4,
   parameter int CntWidth      = 16,
   parameter int TimeoutCycles = 1024,
   localparam int NumW         = $clog2(NrClusters) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumW-1:0]       num_clusters_i,
   input  logic [NrClusters-1:0] idx_completed_i,
   output logic [NrClusters-1:0] idx_completed_sync_o,
   output logic                  barrier_busy_o,
   output logic [CntWidth-1:0]   barrier_cnt_o,
   output logic                  error_o,
   output logic                  timeout_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [NumW-1:0] NrMax = NumW'(NrClusters);

   state_t                  state_q;
   logic [NrClusters-1:0]   arr_q;
   logic [NumW-1:0]         num_q;
   logic [NrClusters-1:0]   sync_q;
   logic                    busy_q;
   logic [CntWidth-1:0]     bcnt_q;
   logic                    err_q;

   logic [NumW-1:0]         num_clamped;
   logic [NrClusters-1:0]   mask_in;
   logic [NrClusters-1:0]   mask_q;
   logic [NrClusters-1:0]   eff_mask;
   logic [NrClusters-1:0]   act;
   logic [NrClusters-1:0]   dup;
   logic                    any_act;
   logic                    done;

   // Clamp the requested cluster count into the legal range 1..NrClusters.
   always_comb begin
      num_clamped = num_clusters_i;
      if (num_clusters_i == '0) begin
         num_clamped = NumW'(1);
      end else if (num_clusters_i > NrMax) begin
         num_clamped = NrMax;
      end
   end

   // Thermometer masks: one from the live (clamped) input, one from the
   // count latched at the start of the current barrier.
   for (genvar gi = 0; gi < NrClusters; gi++) begin : g_mask
      assign mask_in[gi] = (NumW'(gi) < num_clamped);
      assign mask_q[gi]  = (NumW'(gi) < num_q);
   end

   // Arrival qualification and completion detection. Outside COLLECT a new
   // barrier may start this cycle, so the live count defines who is active.
   always_comb begin
      eff_mask = (state_q == COLLECT) ? mask_q : mask_in;
      act      = idx_completed_i & eff_mask;
      dup      = arr_q & act;
      any_act  = |act;
      done     = (((arr_q | act) & eff_mask) == eff_mask);
   end

   // Barrier state machine with registered release, busy, count and error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         arr_q   <= '0;
         num_q   <= NumW'(1);
         sync_q  <= '0;
         busy_q  <= 1'b0;
         bcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         sync_q <= '0;
         if (|dup) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE, RELEASE: begin
               if (state_q == RELEASE) begin
                  bcnt_q <= bcnt_q + CntWidth'(1);
               end
               if (any_act) begin
                  // First arrival of a new barrier fixes the active count.
                  num_q  <= num_clamped;
                  busy_q <= 1'b1;
                  if (done) begin
                     state_q <= RELEASE;
                     sync_q  <= mask_in;
                     arr_q   <= '0;
                  end else begin
                     state_q <= COLLECT;
                     arr_q   <= act;
                  end
               end else begin
                  state_q <= IDLE;
                  arr_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            COLLECT: begin
               busy_q <= 1'b1;
               if (done) begin
                  state_q <= RELEASE;
                  sync_q  <= mask_q;
                  arr_q   <= '0;
               end else begin
                  arr_q <= arr_q | act;
               end
            end
            default: begin
               state_q <= IDLE;
               arr_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign idx_completed_sync_o = sync_q;
   assign barrier_busy_o       = busy_q;
   assign barrier_cnt_o        = bcnt_q;
   assign error_o              = err_q;

`ifdef IDX_SYNC_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCycles + 1);

   logic [TmoW-1:0] tmo_cnt_q;
   logic            tmo_q;

   // Watchdog: counts cycles spent in COLLECT, saturates, and flags a
   // stalled barrier without disturbing the collected arrivals.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else if (state_q == COLLECT) begin
         if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
            tmo_q <= 1'b1;
         end
         if (tmo_cnt_q != TmoW'(TimeoutCycles)) begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
         end
      end else begin
         tmo_cnt_q <= '0;
      end
   end

   assign timeout_o = tmo_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TimeoutCycles > 0);
   assign timeout_o      = 1'b0;
`endif

endmodule
